det_peak_finder: RTL



---
 rtl/surf_pkg.sv | 51 +++++
 rtl/det_nbr_addr.sv | 27 ++
 rtl/det_peak_finder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/surf_pkg.sv
// Shared SURF types: map geometry, neighbour offsets
// and the peak-finder state encoding.
package surf_pkg;

  localparam int SURF_COL     = 320;
  localparam int SURF_ROW     = 240;
  localparam int SURF_MARGIN  = 4;
  localparam int SURF_A_WIDTH = 17;
  localparam int SURF_D_WIDTH = 16;

  localparam int RW = 8;
  localparam int CW = 9;
  localparam int IW = 4;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } nbr_off_t;

  // Centre first so the comparator can seed the peak flag.
  localparam nbr_off_t NBR_TAB [0:8] = '{
    '{dr:  2'sd0, dc:  2'sd0},
    '{dr: -2'sd1, dc: -2'sd1},
    '{dr: -2'sd1, dc:  2'sd0},
    '{dr: -2'sd1, dc:  2'sd1},
    '{dr:  2'sd0, dc: -2'sd1},
    '{dr:  2'sd0, dc:  2'sd1},
    '{dr:  2'sd1, dc: -2'sd1},
    '{dr:  2'sd1, dc:  2'sd0},
    '{dr:  2'sd1, dc:  2'sd1}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_t;

  function automatic nbr_off_t nbr_off(
    input logic [IW-1:0] idx
  );
    nbr_off_t o;
    o = '0;
    if (idx < IW'(9)) o = NBR_TAB[idx];
    return o;
  endfunction

endpackage

// File: rtl/det_nbr_addr.sv
// Maps a candidate centre and neighbour index to
// a determinant memory address.
module det_nbr_addr
  import surf_pkg::*;
#(
  parameter int COL     = SURF_COL,
  parameter int A_WIDTH = SURF_A_WIDTH
) (
  input  logic               en,
  input  logic [RW-1:0]      row,
  input  logic [CW-1:0]      col,
  input  logic [IW-1:0]      idx,
  output logic [A_WIDTH-1:0] addr
);

  nbr_off_t off;
  int       r;
  int       c;

  always_comb begin
    off  = nbr_off(idx);
    r    = int'(row) + int'($signed(off.dr));
    c    = int'(col) + int'($signed(off.dc));
    addr = en ? A_WIDTH'(r * COL + c) : '0;
  end

endmodule

// File: rtl/det_peak_finder.sv
// Scans the determinant map for 3x3 strict local maxima
// above a threshold and streams them as keypoints.
module det_peak_finder
  import surf_pkg::*;
#(
  parameter int COL     = SURF_COL,
  parameter int ROW     = SURF_ROW,
  parameter int MARGIN  = SURF_MARGIN,
  parameter int A_WIDTH = SURF_A_WIDTH,
  parameter int D_WIDTH = SURF_D_WIDTH
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Go,
  input  logic signed [D_WIDTH-1:0] Threshold,
  output logic [A_WIDTH-1:0]        D_Addr,
  output logic                      D_En,
  input  logic signed [D_WIDTH-1:0] D_Data,
  output logic                      Kp_Valid,
  input  logic                      Kp_Ready,
  output logic [RW-1:0]             Kp_Row,
  output logic [CW-1:0]             Kp_Col,
  output logic signed [D_WIDTH-1:0] Kp_Val,
  output logic [15:0]               Kp_Count,
  output logic                      Busy,
  output logic                      Done
);

  localparam logic [RW-1:0] R_FIRST = RW'(MARGIN + 1);
  localparam logic [RW-1:0] R_LAST  = RW'(ROW - MARGIN - 2);
  localparam logic [CW-1:0] C_FIRST = CW'(MARGIN + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(COL - MARGIN - 2);
  localparam logic [IW-1:0] IDX_END = IW'(8);
  localparam logic [15:0]   CNT_MAX = '1;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic                       wcnt_q, wcnt_d;
  logic signed [D_WIDTH-1:0]  thr_q, thr_d;
  logic signed [D_WIDTH-1:0]  ctr_q, ctr_d;
  logic                       peak_q, peak_d;
  logic                       en1_q, en1_d;
  logic                       en2_q, en2_d;
  logic [IW-1:0]              ix1_q, ix1_d;
  logic [IW-1:0]              ix2_q, ix2_d;
  logic [RW-1:0]              kp_row_q, kp_row_d;
  logic [CW-1:0]              kp_col_q, kp_col_d;
  logic signed [D_WIDTH-1:0]  kp_val_q, kp_val_d;
  logic [15:0]                kp_cnt_q, kp_cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic fetch_en;
  logic step;
  logic last_col;
  logic last_row;

  assign fetch_en = (state_q == S_FETCH);
  assign last_col = (col_q == C_LAST);
  assign last_row = (row_q == R_LAST);

  det_nbr_addr #(
    .COL     (COL),
    .A_WIDTH (A_WIDTH)
  ) u_addr (
    .en   (fetch_en),
    .row  (row_q),
    .col  (col_q),
    .idx  (idx_q),
    .addr (D_Addr)
  );

  assign D_En     = fetch_en;
  assign Kp_Valid = (state_q == S_EMIT);
  assign Kp_Row   = kp_row_q;
  assign Kp_Col   = kp_col_q;
  assign Kp_Val   = kp_val_q;
  assign Kp_Count = kp_cnt_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    wcnt_d   = wcnt_q;
    thr_d    = thr_q;
    ctr_d    = ctr_q;
    peak_d   = peak_q;
    kp_row_d = kp_row_q;
    kp_col_d = kp_col_q;
    kp_val_d = kp_val_q;
    kp_cnt_d = kp_cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    step     = 1'b0;

    // Read data trails its address by the memory latency.
    en1_d = fetch_en;
    ix1_d = idx_q;
    en2_d = en1_q;
    ix2_d = ix1_q;
    if (en2_q) begin
      if (ix2_q == '0) begin
        ctr_d  = D_Data;
        peak_d = (D_Data > thr_q);
      end else begin
        peak_d = peak_q && (ctr_q > D_Data);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (Go) begin
          thr_d    = Threshold;
          kp_cnt_d = '0;
          busy_d   = 1'b1;
          row_d    = R_FIRST;
          col_d    = C_FIRST;
          idx_d    = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (idx_q == IDX_END) begin
          idx_d   = '0;
          wcnt_d  = 1'b0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WAIT: begin
        if (wcnt_q) state_d = S_EVAL;
        else        wcnt_d  = 1'b1;
      end
      S_EVAL: begin
        if (peak_q) begin
          kp_row_d = row_q;
          kp_col_d = col_q;
          kp_val_d = ctr_q;
          state_d  = S_EMIT;
        end else begin
          step = 1'b1;
        end
      end
      S_EMIT: begin
        if (Kp_Ready) begin
          if (kp_cnt_q != CNT_MAX)
            kp_cnt_d = kp_cnt_q + 16'd1;
          step = 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Advance the raster position; this is the NEXT step,
    // folded into EVAL/EMIT so it costs no extra cycle.
    if (step) begin
      if (last_col) begin
        col_d = C_FIRST;
        if (last_row) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_FETCH;
        end
      end else begin
        col_d   = col_q + CW'(1);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      wcnt_q   <= 1'b0;
      thr_q    <= '0;
      ctr_q    <= '0;
      peak_q   <= 1'b0;
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
      ix1_q    <= '0;
      ix2_q    <= '0;
      kp_row_q <= '0;
      kp_col_q <= '0;
      kp_val_q <= '0;
      kp_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wcnt_q   <= wcnt_d;
      thr_q    <= thr_d;
      ctr_q    <= ctr_d;
      peak_q   <= peak_d;
      en1_q    <= en1_d;
      en2_q    <= en2_d;
      ix1_q    <= ix1_d;
      ix2_q    <= ix2_d;
      kp_row_q <= kp_row_d;
      kp_col_q <= kp_col_d;
      kp_val_q <= kp_val_d;
      kp_cnt_q <= kp_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
